// File: rtl/raycast_pkg.sv
// Shared types and constants for the raycaster ray-marching engine.
//   fix_t  : Q8.8 signed world coordinate / step component
//   FRAC   : number of fractional bits in fix_t
//   state_t: engine FSM state encoding
package raycast_pkg;

  typedef logic signed [15:0] fix_t;

  localparam int FRAC = 8;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StSetup = 3'd1;
  localparam state_t StMarch = 3'd2;
  localparam state_t StWrite = 3'd3;
  localparam state_t StDone  = 3'd4;

endpackage

// File: rtl/ray_trig_lut.sv
// Elaboration-time sine table scaled by the ray step length.
// Entries are sin(2*pi*i/ANGLES) * STEP (STEP is raw Q8.8), truncated toward zero.
// Ports:
//   a_in   : ray angle index
//   dx_out : cos(a) * STEP, Q8.8
//   dy_out : sin(a) * STEP, Q8.8
module ray_trig_lut
  import raycast_pkg::*;
#(
  parameter int unsigned ANGLES = 256,
  parameter logic [15:0] STEP   = 16'h0080
) (
  input  logic [$clog2(ANGLES)-1:0] a_in,
  output fix_t                      dx_out,
  output fix_t                      dy_out
);

  localparam int unsigned AW = $clog2(ANGLES);
  localparam real PI = 3.14159265358979323846;

  fix_t sin_tab [ANGLES];

  for (genvar i = 0; i < ANGLES; i++) begin : g_tab
    localparam real Val = $sin(2.0 * PI * real'(i) / real'(ANGLES)) * real'(STEP);
    assign sin_tab[i] = fix_t'($rtoi(Val));
  end

  // cos(a) = sin(a + quarter turn); the AW-bit add wraps mod ANGLES.
  logic [AW-1:0] a_cos;
  assign a_cos  = a_in + AW'(ANGLES / 4);
  assign dx_out = sin_tab[a_cos];
  assign dy_out = sin_tab[a_in];

endmodule

// File: rtl/raycast_engine.sv
// Per-frame ray-marching engine. On frame_in it latches the player pose and
// marches one ray per screen column over a tile map, storing each column's hit
// distance in the back half of a ping-pong column buffer. Buffers swap when the
// frame completes.
// Ports:
//   clk_in, rst_in        : clock, asynchronous active-high reset
//   frame_in              : one-cycle frame start pulse
//   px_in, py_in, pa_in   : player position (Q8.8) and heading
//   map_we_in/addr/data   : tile map bit write port (addr = y*MAP_X+x)
//   col_in / dist_out     : renderer read column / registered distance (front buffer)
//   busy_out, done_out    : marching in progress / frame-complete pulse
//   overrun_out           : sticky, frame_in arrived while busy
module raycast_engine
  import raycast_pkg::*;
#(
  parameter int unsigned COLS       = 640,
  parameter int unsigned ANGLES     = 256,
  parameter int unsigned COL_SHIFT  = 4,
  parameter int unsigned MAP_X      = 8,
  parameter int unsigned MAP_Y      = 8,
  parameter int unsigned CELL_SHIFT = 3,
  parameter logic [15:0] STEP       = 16'h0080,
  parameter int unsigned MAX_STEPS  = 255
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 frame_in,
  input  fix_t                                 px_in,
  input  fix_t                                 py_in,
  input  logic [$clog2(ANGLES)-1:0]            pa_in,
  input  logic                                 map_we_in,
  input  logic [$clog2(MAP_X*MAP_Y)-1:0]       map_addr_in,
  input  logic                                 map_data_in,
  input  logic [$clog2(COLS)-1:0]              col_in,
  output logic [$clog2(MAX_STEPS+1)-1:0]       dist_out,
  output logic                                 busy_out,
  output logic                                 done_out,
  output logic                                 overrun_out
);

  localparam int unsigned AW = $clog2(ANGLES);
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned MW = $clog2(MAP_X * MAP_Y);
  localparam int unsigned DW = $clog2(MAX_STEPS + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [AW-1:0] pa_q, pa_d;
  fix_t          px_q, px_d, py_q, py_d;
  fix_t          x_q, x_d, y_q, y_d;
  fix_t          dx_q, dx_d, dy_q, dy_d;
  logic [DW-1:0] step_q, step_d;
  logic          front_q, front_d;
  logic          overrun_q, overrun_d;
  logic [DW-1:0] dist_q;

  logic [MAP_X*MAP_Y-1:0] map_q;
  logic [DW-1:0]          buf0 [COLS];
  logic [DW-1:0]          buf1 [COLS];

  // Ray angle for the current column, wrapping mod ANGLES in AW bits.
  logic [AW-1:0] ray_a;
  fix_t          lut_dx, lut_dy;
  assign ray_a = pa_q + AW'(col_q >> COL_SHIFT) - AW'((COLS >> COL_SHIFT) >> 1);

  ray_trig_lut #(
    .ANGLES (ANGLES),
    .STEP   (STEP)
  ) u_lut (
    .a_in   (ray_a),
    .dx_out (lut_dx),
    .dy_out (lut_dy)
  );

  // Cell lookup; only meaningful when x and y are non-negative, which the
  // sign-bit terms guarantee before the map bit can decide the hit.
  logic [15:0] cx, cy;
  logic        hit;
  assign cx  = unsigned'(x_q) >> (FRAC + CELL_SHIFT);
  assign cy  = unsigned'(y_q) >> (FRAC + CELL_SHIFT);
  assign hit = x_q[15] || y_q[15] || (cx >= 16'(MAP_X)) || (cy >= 16'(MAP_Y)) ||
               map_q[MW'(cy * 16'(MAP_X) + cx)];

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    pa_d      = pa_q;
    px_d      = px_q;
    py_d      = py_q;
    x_d       = x_q;
    y_d       = y_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    step_d    = step_q;
    front_d   = front_q;
    overrun_d = overrun_q;
    case (state_q)
      StIdle: begin
        if (frame_in) begin
          px_d    = px_in;
          py_d    = py_in;
          pa_d    = pa_in;
          col_d   = '0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        x_d     = px_q;
        y_d     = py_q;
        dx_d    = lut_dx;
        dy_d    = lut_dy;
        step_d  = '0;
        state_d = StMarch;
      end
      StMarch: begin
        // On exit step_q holds the distance written in StWrite.
        if (hit || (step_q == DW'(MAX_STEPS))) begin
          state_d = StWrite;
        end else begin
          x_d    = x_q + dx_q;
          y_d    = y_q + dy_q;
          step_d = step_q + DW'(1);
        end
      end
      StWrite: begin
        if (col_q == CW'(COLS - 1)) begin
          state_d = StDone;
        end else begin
          col_d   = col_q + CW'(1);
          state_d = StSetup;
        end
      end
      StDone: begin
        front_d = ~front_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Any frame request outside IDLE (including DONE) is dropped and flagged.
    if (frame_in && (state_q != StIdle)) overrun_d = 1'b1;
  end

  // In the DONE cycle the read already targets the buffer about to become front.
  logic rd_sel;
  assign rd_sel = (state_q == StDone) ? ~front_q : front_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= StIdle;
      col_q     <= '0;
      pa_q      <= '0;
      px_q      <= '0;
      py_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      step_q    <= '0;
      front_q   <= 1'b0;
      overrun_q <= 1'b0;
      dist_q    <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      pa_q      <= pa_d;
      px_q      <= px_d;
      py_q      <= py_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      step_q    <= step_d;
      front_q   <= front_d;
      overrun_q <= overrun_d;
      dist_q    <= rd_sel ? buf1[col_in] : buf0[col_in];
    end
  end

  // Storage without reset: map bits and column buffers (back = !front).
  always_ff @(posedge clk_in) begin
    if (map_we_in) map_q[map_addr_in] <= map_data_in;
    if (state_q == StWrite) begin
      if (front_q) buf0[col_q] <= step_q;
      else         buf1[col_q] <= step_q;
    end
  end

  assign busy_out    = (state_q == StSetup) || (state_q == StMarch) || (state_q == StWrite);
  assign done_out    = (state_q == StDone);
  assign overrun_out = overrun_q;
  assign dist_out    = dist_q;

endmodule

// File: tb/tb_raycast_engine.sv
// Directed bench for raycast_engine. Instance a uses COLS=4, COL_SHIFT=0 and the
// default MAX_STEPS; instance b is identical except MAX_STEPS=10. Both share inputs.
// Ray angles for pa=0: columns 0..3 -> 254, 255, 0, 1. Step vectors (truncated):
// a=254 (127,-6), a=255 (127,-3), a=0 (128,0), a=1 (127,3). Player at 0x1400.
module tb_raycast_engine;
  import raycast_pkg::*;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       frame_in = 1'b0;
  fix_t       px_in = '0;
  fix_t       py_in = '0;
  logic [7:0] pa_in = '0;
  logic       map_we_in = 1'b0;
  logic [5:0] map_addr_in = '0;
  logic       map_data_in = 1'b0;
  logic [1:0] col_in = '0;

  logic [7:0] dist_a;
  logic       busy_a, done_a, ovr_a;
  logic [3:0] dist_b;
  logic       busy_b, done_b, ovr_b;

  int checks = 0;
  int errors = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  int cyc_a, cyc_b, cnt_a0, cnt_b0;

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (done_a) done_cnt_a <= done_cnt_a + 1;
    if (done_b) done_cnt_b <= done_cnt_b + 1;
  end

  raycast_engine #(
    .COLS      (4),
    .COL_SHIFT (0)
  ) u_dut_a (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .frame_in    (frame_in),
    .px_in       (px_in),
    .py_in       (py_in),
    .pa_in       (pa_in),
    .map_we_in   (map_we_in),
    .map_addr_in (map_addr_in),
    .map_data_in (map_data_in),
    .col_in      (col_in),
    .dist_out    (dist_a),
    .busy_out    (busy_a),
    .done_out    (done_a),
    .overrun_out (ovr_a)
  );

  raycast_engine #(
    .COLS      (4),
    .COL_SHIFT (0),
    .MAX_STEPS (10)
  ) u_dut_b (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .frame_in    (frame_in),
    .px_in       (px_in),
    .py_in       (py_in),
    .pa_in       (pa_in),
    .map_we_in   (map_we_in),
    .map_addr_in (map_addr_in),
    .map_data_in (map_data_in),
    .col_in      (col_in),
    .dist_out    (dist_b),
    .busy_out    (busy_b),
    .done_out    (done_b),
    .overrun_out (ovr_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic map_write(input int addr, input logic val);
    map_addr_in = 6'(addr);
    map_data_in = val;
    map_we_in   = 1'b1;
    @(negedge clk_in);
    map_we_in   = 1'b0;
  endtask

  // Starts a frame and waits (bounded) for both done pulses. Cycle counts are
  // relative to the sampling edge t, so the first counted cycle is t+1.
  // In a's done cycle col_in is set to 2 to exercise the handoff read.
  // dup_at > 0 re-pulses frame_in (with a different pose) in that cycle.
  task automatic run_frame(input fix_t px, input fix_t py, input logic [7:0] pa,
                           input int dup_at, output int ca, output int cb);
    int cyc;
    ca = -1;
    cb = -1;
    px_in = px;
    py_in = py;
    pa_in = pa;
    frame_in = 1'b1;
    @(negedge clk_in);
    frame_in = 1'b0;
    cyc = 1;
    check("busy_at_start", 32'(busy_a), 32'd1);
    while (1) begin
      if (done_a && ca < 0) begin
        ca = cyc;
        col_in = 2'd2;
        check("busy_at_done", 32'(busy_a), 32'd0);
      end
      if (done_b && cb < 0) cb = cyc;
      if ((ca >= 0 && cb >= 0) || cyc >= 1000) break;
      frame_in = (cyc == dup_at);
      if (cyc == dup_at) begin
        pa_in = 8'd64;
        px_in = 16'sh0000;
      end
      @(negedge clk_in);
      cyc++;
    end
    frame_in = 1'b0;
  endtask

  task automatic read_col(input string tag, input int c, input int exp_a, input int exp_b);
    col_in = 2'(c);
    @(negedge clk_in);
    check({tag, "_a"}, 32'(dist_a), 32'(exp_a));
    check({tag, "_b"}, 32'(dist_b), 32'(exp_b));
  endtask

  initial begin
    #1 rst_in = 1'b1;
    @(negedge clk_in);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_ovr", 32'(ovr_a), 32'd0);
    check("rst_dist", 32'(dist_a), 32'd0);
    rst_in = 1'b0;
    @(negedge clk_in);
    for (int i = 0; i < 64; i++) map_write(i, 1'b0);

    // Empty map: walls only at the map edge (x = 64.0).
    run_frame(16'sh1400, 16'sh1400, 8'd0, 0, cyc_a, cyc_b);
    check("empty_done_cyc_a", 32'(cyc_a), 32'd368);
    check("empty_done_cyc_b", 32'(cyc_b), 32'd53);
    @(negedge clk_in);
    check("empty_handoff_col2", 32'(dist_a), 32'd88);
    read_col("empty_col0", 0, 89, 10);
    read_col("empty_col1", 1, 89, 10);
    read_col("empty_col2", 2, 88, 10);
    read_col("empty_col3", 3, 89, 10);

    // Wall at cell (4,2): boundary at x = 32.0.
    map_write(20, 1'b1);
    run_frame(16'sh1400, 16'sh1400, 8'd0, 0, cyc_a, cyc_b);
    check("wall_done_cyc_a", 32'(cyc_a), 32'd112);
    check("wall_done_cyc_b", 32'(cyc_b), 32'd53);
    @(negedge clk_in);
    check("wall_handoff_col2", 32'(dist_a), 32'd24);
    read_col("wall_col0", 0, 25, 10);
    read_col("wall_col1", 1, 25, 10);
    read_col("wall_col3", 3, 25, 10);

    // Player standing inside a wall cell (2,2): every column hits at step 0.
    map_write(18, 1'b1);
    run_frame(16'sh1400, 16'sh1400, 8'd0, 0, cyc_a, cyc_b);
    check("inside_done_cyc_a", 32'(cyc_a), 32'd13);
    check("inside_done_cyc_b", 32'(cyc_b), 32'd13);
    read_col("inside_col0", 0, 0, 0);
    read_col("inside_col2", 2, 0, 0);
    read_col("inside_col3", 3, 0, 0);

    // Second frame_in while busy: ignored, sticky overrun, single done.
    map_write(18, 1'b0);
    check("ovr_before", 32'(ovr_a), 32'd0);
    cnt_a0 = done_cnt_a;
    cnt_b0 = done_cnt_b;
    run_frame(16'sh1400, 16'sh1400, 8'd0, 5, cyc_a, cyc_b);
    check("ovr_done_cyc_a", 32'(cyc_a), 32'd112);
    check("ovr_flag_a", 32'(ovr_a), 32'd1);
    check("ovr_flag_b", 32'(ovr_b), 32'd1);
    read_col("ovr_col2", 2, 24, 10);
    read_col("ovr_col0", 0, 25, 10);
    repeat (50) @(negedge clk_in);
    check("ovr_single_done_a", 32'(done_cnt_a - cnt_a0), 32'd1);
    check("ovr_single_done_b", 32'(done_cnt_b - cnt_b0), 32'd1);
    check("ovr_sticky", 32'(ovr_a), 32'd1);

    // Reset mid-MARCH of column 0: asynchronous abort, no done pulse.
    col_in = 2'd2;
    cnt_a0 = done_cnt_a;
    px_in = 16'sh1400;
    py_in = 16'sh1400;
    pa_in = 8'd0;
    frame_in = 1'b1;
    @(negedge clk_in);
    frame_in = 1'b0;
    repeat (10) @(negedge clk_in);
    check("mid_busy", 32'(busy_a), 32'd1);
    #2 rst_in = 1'b1;
    #1;
    check("arst_busy", 32'(busy_a), 32'd0);
    check("arst_done", 32'(done_a), 32'd0);
    check("arst_ovr", 32'(ovr_a), 32'd0);
    check("arst_dist", 32'(dist_a), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (400) @(negedge clk_in);
    check("arst_no_done", 32'(done_cnt_a - cnt_a0), 32'd0);

    run_frame(16'sh1400, 16'sh1400, 8'd0, 0, cyc_a, cyc_b);
    check("post_rst_done_cyc_a", 32'(cyc_a), 32'd112);
    @(negedge clk_in);
    check("post_rst_handoff_col2", 32'(dist_a), 32'd24);
    read_col("post_rst_col1", 1, 25, 10);
    check("post_rst_ovr", 32'(ovr_a), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
